rob_commit_unit: RTL and testbench

- In-order retirement stage directly downstream of the 4-entry reorder-buffer FIFO in the 4-way out-of-order core.
- Each cycle it inspects up to 4 oldest ROB entries and retires the longest eligible prefix, combinationally returning the pop count to the ROB.
- Produces registered architectural-register-map updates and a retired-instruction count.
- On an excepting head it flushes the pipeline and blocks further retirement until the front end acknowledges the redirect.

---
 rtl/rob_commit_unit.sv | 102 ++++++++++
 tb/tb_rob_commit_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order ROB retirement with exception flush; COMMIT_PERF_CNT_EN adds stall/store-block counters
module rob_commit_unit #(
    parameter int COMMIT_W = 4,
    parameter int ENTRY_W  = 28,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [COMMIT_W*ENTRY_W-1:0]  head_entry,
    input  logic [COMMIT_W-1:0]          head_valid,
    input  logic                         store_ready,
    input  logic                         redirect_done,
    output logic [2:0]                   pop_cnt,
    output logic [COMMIT_W-1:0]          rat_we,
    output logic [5*COMMIT_W-1:0]        rat_rd,
    output logic [7*COMMIT_W-1:0]        rat_prd,
    output logic                         store_commit,
    output logic                         flush,
    output logic [11:0]                  exc_pc,
    output logic [CNT_W-1:0]             retired_cnt
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             store_block_cycles
`endif
);
    typedef enum logic [1:0] {RUN, FLUSH, WAIT_REDIR} state_t;
    state_t state, state_nxt;
    logic [COMMIT_W-1:0] elig;
    logic [2:0] cnt;
    logic ok, st, exc_head;
    logic unused_ok;
    assign unused_ok = ^head_entry;
    always_comb begin
        elig = '0;
        cnt = 3'd0;
        ok = (state == RUN);
        st = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            ok = ok && head_valid[i] && head_entry[i*ENTRY_W+27] && !head_entry[i*ENTRY_W+26]
                 && !(head_entry[i*ENTRY_W+25] && (st || !store_ready));
            elig[i] = ok;
            st = st || (ok && head_entry[i*ENTRY_W+25]);
            cnt = cnt + {2'b0, ok};
        end
    end
    assign exc_head = (state == RUN) && head_valid[0] && head_entry[27] && head_entry[26];
    assign pop_cnt = !reset_n ? 3'd0 : exc_head ? 3'd1 : cnt;
    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN) ? (exc_head ? FLUSH : RUN) :
                    (state == FLUSH) ? WAIT_REDIR :
                    (redirect_done ? RUN : WAIT_REDIR);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            rat_we <= '0;
            rat_rd <= '0;
            rat_prd <= '0;
            store_commit <= 1'b0;
            flush <= 1'b0;
            exc_pc <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            flush <= exc_head;
            if (exc_head) exc_pc <= head_entry[11:0];
            store_commit <= st;
            retired_cnt <= retired_cnt + CNT_W'(cnt);
            for (int i = 0; i < COMMIT_W; i++) begin
                rat_we[i] <= elig[i] && head_entry[i*ENTRY_W+19];
                rat_rd[i*5 +: 5] <= head_entry[i*ENTRY_W+20 +: 5];
                rat_prd[i*7 +: 7] <= head_entry[i*ENTRY_W+12 +: 7];
            end
        end
    end
`ifdef COMMIT_PERF_CNT_EN
    logic ok_sr, st_sr;
    logic [2:0] cnt_sr;
    always_comb begin
        cnt_sr = 3'd0;
        ok_sr = (state == RUN);
        st_sr = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            ok_sr = ok_sr && head_valid[i] && head_entry[i*ENTRY_W+27] && !head_entry[i*ENTRY_W+26]
                    && !(head_entry[i*ENTRY_W+25] && st_sr);
            st_sr = st_sr || (ok_sr && head_entry[i*ENTRY_W+25]);
            cnt_sr = cnt_sr + {2'b0, ok_sr};
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            store_block_cycles <= '0;
        end else begin
            if (state == RUN && head_valid[0] && pop_cnt == 3'd0) stall_cycles <= stall_cycles + 1'b1;
            if (state == RUN && cnt_sr > cnt) store_block_cycles <= store_block_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed self-checking bench for rob_commit_unit
module tb_rob_commit_unit;
    logic clk = 1'b0;
    logic reset_n;
    logic [4*28-1:0] head_entry;
    logic [3:0] head_valid;
    logic store_ready, redirect_done;
    logic [2:0] pop_cnt;
    logic [3:0] rat_we;
    logic [19:0] rat_rd;
    logic [27:0] rat_prd;
    logic store_commit, flush;
    logic [11:0] exc_pc;
    logic [31:0] retired_cnt;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] stall_cycles, store_block_cycles;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_commit_unit dut (
        .clk(clk), .reset_n(reset_n), .head_entry(head_entry), .head_valid(head_valid),
        .store_ready(store_ready), .redirect_done(redirect_done), .pop_cnt(pop_cnt),
        .rat_we(rat_we), .rat_rd(rat_rd), .rat_prd(rat_prd), .store_commit(store_commit),
        .flush(flush), .exc_pc(exc_pc), .retired_cnt(retired_cnt)
`ifdef COMMIT_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .store_block_cycles(store_block_cycles)
`endif
    );

    function automatic logic [27:0] mk(input logic d, input logic x, input logic s, input logic [4:0] rd,
                                       input logic rv, input logic [6:0] prd, input logic [11:0] pc);
        return {d, x, s, rd, rv, prd, pc};
    endfunction

    task automatic load(input logic [27:0] e0, input logic [27:0] e1, input logic [27:0] e2, input logic [27:0] e3);
        head_entry = {e3, e2, e1, e0};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_plain;
        load(mk(1,0,0,5'd1,1,7'd10,12'h0), mk(1,0,0,5'd2,1,7'd11,12'h0),
             mk(1,0,0,5'd3,1,7'd12,12'h0), mk(1,0,0,5'd4,1,7'd13,12'h0));
    endtask

    task automatic test_reset;
        reset_n = 1'b0; head_valid = 4'b0; store_ready = 1'b1; redirect_done = 1'b0;
        load_plain();
        head_valid = 4'b1111;
        #2;
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL reset_pop got=%0d exp=0", pop_cnt); end
        step();
        checks++; if (rat_we !== 4'b0) begin failures++; $display("FAIL reset_rat_we got=%b exp=0000", rat_we); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (exc_pc !== 12'h0) begin failures++; $display("FAIL reset_exc_pc got=%h exp=000", exc_pc); end
        checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired_cnt); end
        checks++; if (store_commit !== 1'b0) begin failures++; $display("FAIL reset_store got=%b exp=0", store_commit); end
        head_valid = 4'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_full_commit;
        load_plain();
        head_valid = 4'b1111;
        #1;
        checks++; if (pop_cnt !== 3'd4) begin failures++; $display("FAIL full_pop got=%0d exp=4", pop_cnt); end
        step();
        head_valid = 4'b0;
        checks++; if (rat_we !== 4'b1111) begin failures++; $display("FAIL full_rat_we got=%b exp=1111", rat_we); end
        checks++; if (rat_rd !== {5'd4,5'd3,5'd2,5'd1}) begin failures++; $display("FAIL full_rat_rd got=%h exp=%h", rat_rd, {5'd4,5'd3,5'd2,5'd1}); end
        checks++; if (rat_prd !== {7'd13,7'd12,7'd11,7'd10}) begin failures++; $display("FAIL full_rat_prd got=%h exp=%h", rat_prd, {7'd13,7'd12,7'd11,7'd10}); end
        checks++; if (retired_cnt !== 32'd4) begin failures++; $display("FAIL full_retired got=%0d exp=4", retired_cnt); end
        checks++; if (store_commit !== 1'b0) begin failures++; $display("FAIL full_store got=%b exp=0", store_commit); end
    endtask

    task automatic test_done_gap;
        load(mk(1,0,0,5'd1,1,7'd10,12'h0), mk(1,0,0,5'd2,1,7'd11,12'h0),
             mk(0,0,0,5'd3,1,7'd12,12'h0), mk(1,0,0,5'd4,1,7'd13,12'h0));
        head_valid = 4'b1111;
        #1;
        checks++; if (pop_cnt !== 3'd2) begin failures++; $display("FAIL gap_pop got=%0d exp=2", pop_cnt); end
        step();
        head_valid = 4'b0;
        checks++; if (rat_we !== 4'b0011) begin failures++; $display("FAIL gap_rat_we got=%b exp=0011", rat_we); end
        checks++; if (retired_cnt !== 32'd6) begin failures++; $display("FAIL gap_retired got=%0d exp=6", retired_cnt); end
    endtask

    task automatic test_stores;
        load(mk(1,0,1,5'd0,0,7'd20,12'h0), mk(1,0,0,5'd5,1,7'd21,12'h0),
             mk(1,0,1,5'd0,0,7'd22,12'h0), mk(1,0,0,5'd6,1,7'd23,12'h0));
        head_valid = 4'b1111;
        store_ready = 1'b1;
        #1;
        checks++; if (pop_cnt !== 3'd2) begin failures++; $display("FAIL store_pop got=%0d exp=2", pop_cnt); end
        step();
        checks++; if (store_commit !== 1'b1) begin failures++; $display("FAIL store_commit got=%b exp=1", store_commit); end
        checks++; if (rat_we !== 4'b0010) begin failures++; $display("FAIL store_rat_we got=%b exp=0010", rat_we); end
        checks++; if (retired_cnt !== 32'd8) begin failures++; $display("FAIL store_retired got=%0d exp=8", retired_cnt); end
        store_ready = 1'b0;
        #1;
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL store_blocked_pop got=%0d exp=0", pop_cnt); end
        step();
        head_valid = 4'b0;
        store_ready = 1'b1;
        checks++; if (store_commit !== 1'b0) begin failures++; $display("FAIL store_blocked_commit got=%b exp=0", store_commit); end
        checks++; if (retired_cnt !== 32'd8) begin failures++; $display("FAIL store_blocked_retired got=%0d exp=8", retired_cnt); end
    endtask

    task automatic test_exception;
        load(mk(1,1,0,5'd7,1,7'd30,12'h3A4), mk(1,0,0,5'd2,1,7'd11,12'h0),
             mk(1,0,0,5'd3,1,7'd12,12'h0), mk(1,0,0,5'd4,1,7'd13,12'h0));
        head_valid = 4'b1111;
        #1;
        checks++; if (pop_cnt !== 3'd1) begin failures++; $display("FAIL exc_pop got=%0d exp=1", pop_cnt); end
        step();
        load_plain();
        redirect_done = 1'b1;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL exc_flush got=%b exp=1", flush); end
        checks++; if (exc_pc !== 12'h3A4) begin failures++; $display("FAIL exc_pc got=%h exp=3a4", exc_pc); end
        checks++; if (rat_we !== 4'b0) begin failures++; $display("FAIL exc_rat_we got=%b exp=0000", rat_we); end
        checks++; if (retired_cnt !== 32'd8) begin failures++; $display("FAIL exc_retired got=%0d exp=8", retired_cnt); end
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL exc_flush_pop got=%0d exp=0", pop_cnt); end
        step();
        redirect_done = 1'b0;
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL exc_flush_pulse got=%b exp=0", flush); end
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL exc_wait_pop got=%0d exp=0", pop_cnt); end
        step();
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL exc_wait2_pop got=%0d exp=0", pop_cnt); end
        checks++; if (exc_pc !== 12'h3A4) begin failures++; $display("FAIL exc_pc_held got=%h exp=3a4", exc_pc); end
        redirect_done = 1'b1;
        step();
        redirect_done = 1'b0;
        head_valid = 4'b0001;
        #1;
        checks++; if (pop_cnt !== 3'd1) begin failures++; $display("FAIL exc_resume_pop got=%0d exp=1", pop_cnt); end
        step();
        head_valid = 4'b0;
        checks++; if (retired_cnt !== 32'd9) begin failures++; $display("FAIL exc_resume_retired got=%0d exp=9", retired_cnt); end
    endtask

    task automatic test_back_to_back;
        load_plain();
        head_valid = 4'b0011;
        #1;
        checks++; if (pop_cnt !== 3'd2) begin failures++; $display("FAIL b2b_a_pop got=%0d exp=2", pop_cnt); end
        step();
        head_valid = 4'b0111;
        checks++; if (rat_we !== 4'b0011) begin failures++; $display("FAIL b2b_a_rat_we got=%b exp=0011", rat_we); end
        #1;
        checks++; if (pop_cnt !== 3'd3) begin failures++; $display("FAIL b2b_b_pop got=%0d exp=3", pop_cnt); end
        step();
        head_valid = 4'b1101;
        checks++; if (rat_we !== 4'b0111) begin failures++; $display("FAIL b2b_b_rat_we got=%b exp=0111", rat_we); end
        #1;
        checks++; if (pop_cnt !== 3'd1) begin failures++; $display("FAIL nonthermo_pop got=%0d exp=1", pop_cnt); end
        step();
        head_valid = 4'b0;
        checks++; if (rat_we !== 4'b0001) begin failures++; $display("FAIL nonthermo_rat_we got=%b exp=0001", rat_we); end
        checks++; if (retired_cnt !== 32'd15) begin failures++; $display("FAIL b2b_retired got=%0d exp=15", retired_cnt); end
    endtask

    task automatic test_reset_wait;
        load(mk(1,1,0,5'd7,1,7'd30,12'h5C1), mk(0,0,0,5'd0,0,7'd0,12'h0),
             mk(0,0,0,5'd0,0,7'd0,12'h0), mk(0,0,0,5'd0,0,7'd0,12'h0));
        head_valid = 4'b0001;
        step();
        head_valid = 4'b0;
        step();
        load_plain();
        head_valid = 4'b0001;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (exc_pc !== 12'h0) begin failures++; $display("FAIL rstw_exc_pc got=%h exp=000", exc_pc); end
        checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL rstw_retired got=%0d exp=0", retired_cnt); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstw_flush got=%b exp=0", flush); end
        checks++; if (pop_cnt !== 3'd0) begin failures++; $display("FAIL rstw_pop got=%0d exp=0", pop_cnt); end
        #1;
        reset_n = 1'b1;
        #1;
        checks++; if (pop_cnt !== 3'd1) begin failures++; $display("FAIL rstw_run_pop got=%0d exp=1", pop_cnt); end
        step();
        head_valid = 4'b0;
        checks++; if (retired_cnt !== 32'd1) begin failures++; $display("FAIL rstw_after_retired got=%0d exp=1", retired_cnt); end
        checks++; if (rat_we !== 4'b0001) begin failures++; $display("FAIL rstw_after_rat_we got=%b exp=0001", rat_we); end
    endtask

`ifdef COMMIT_PERF_CNT_EN
    task automatic test_perf;
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        load(mk(0,0,0,5'd1,1,7'd10,12'h0), mk(1,0,0,5'd2,1,7'd11,12'h0),
             mk(1,0,0,5'd3,1,7'd12,12'h0), mk(1,0,0,5'd4,1,7'd13,12'h0));
        head_valid = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        checks++; if (stall_cycles !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles); end
        checks++; if (store_block_cycles !== 32'd0) begin failures++; $display("FAIL perf_sblock0 got=%0d exp=0", store_block_cycles); end
        load(mk(1,0,1,5'd0,0,7'd20,12'h0), mk(1,0,0,5'd5,1,7'd21,12'h0),
             mk(1,0,0,5'd6,1,7'd22,12'h0), mk(1,0,0,5'd7,1,7'd23,12'h0));
        store_ready = 1'b0;
        for (int i = 0; i < 2; i++) step();
        head_valid = 4'b0;
        store_ready = 1'b1;
        checks++; if (store_block_cycles !== 32'd2) begin failures++; $display("FAIL perf_sblock got=%0d exp=2", store_block_cycles); end
        checks++; if (stall_cycles !== 32'd7) begin failures++; $display("FAIL perf_stall2 got=%0d exp=7", stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_commit();
        test_done_gap();
        test_stores();
        test_exception();
        test_back_to_back();
        test_reset_wait();
`ifdef COMMIT_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
